trivium_stream_cipher: RTL and testbench

TRIVIUM_STREAM_CIPHER -- requirements
Module: trivium_stream_cipher

---
 rtl/trivium_pkg.sv | 19 +
 rtl/trivium_sync_fifo.sv | 68 ++++++
 rtl/trivium_stream_cipher.sv | 108 ++++++++++
 tb/tb_trivium_stream_cipher.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trivium_pkg.sv
// trivium_pkg: shared types and constants for the Trivium stream-cipher datapath.
//   state_e       : control FSM states (RUN, FLUSH, WAIT_LOW, WAIT_HIGH)
//   LANES_DEFAULT : default bytes per data beat
//   DEPTH_DEFAULT : default output FIFO depth
//   BYTE_CNT_W    : width of the optional byte counter
package trivium_pkg;

   typedef enum logic [1:0] {
      ST_RUN       = 2'd0,
      ST_FLUSH     = 2'd1,
      ST_WAIT_LOW  = 2'd2,
      ST_WAIT_HIGH = 2'd3
   } state_e;

   localparam int unsigned LANES_DEFAULT = 1;
   localparam int unsigned DEPTH_DEFAULT = 10;
   localparam int unsigned BYTE_CNT_W    = 32;

endpackage

// File: rtl/trivium_sync_fifo.sv
// trivium_sync_fifo: first-word-fall-through synchronous FIFO, any depth >= 2.
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : synchronous flush (pointers and level to zero), dominates wr/rd
//   wr_en      : write request, ignored when full
//   wr_data    : write data
//   rd_en      : pop request, ignored when empty
//   rd_data    : head entry, forced to zero while empty
//   full/empty : occupancy flags (registered level compare)
//   level      : current occupancy
module trivium_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 10
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] level
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned LVL_W = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0] count_q;
   logic             wr_fire, rd_fire;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count_q == LVL_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign level   = count_q;
   assign wr_fire = wr_en && !full;
   assign rd_fire = rd_en && !empty;
   assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (clr) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (wr_fire) wr_ptr_q <= ptr_inc(wr_ptr_q);
         if (rd_fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
         if (wr_fire && !rd_fire)      count_q <= count_q + LVL_W'(1);
         else if (rd_fire && !wr_fire) count_q <= count_q - LVL_W'(1);
      end
   end

   // Storage needs no reset: rd_data is masked while empty.
   always_ff @(posedge clk) begin
      if (wr_fire) mem_q[wr_ptr_q] <= wr_data;
   end

endmodule

// File: rtl/trivium_stream_cipher.sv
// trivium_stream_cipher: XORs plaintext beats with Trivium keystream into an
// output FIFO, with bypass and a resync (flush + generator reload) sequence.
//   clk, rst_n          : clock, asynchronous active-low reset
//   s_data/valid/ready  : plaintext beat handshake (8*LANES bits)
//   m_data/valid/ready  : ciphertext beat handshake, FIFO head
//   ks_data/ks_valid    : keystream beat from the generator
//   ks_read             : combinational pulse consuming one keystream beat
//   bypass              : pass plaintext through unencrypted
//   resync              : request flush and keystream re-initialisation
//   resync_req          : registered pulse asking the generator to reload key/IV
//   fifo_level          : current FIFO occupancy
//   byte_count          : bytes accepted (only with TRIVIUM_STREAM_CNT_EN defined)
module trivium_stream_cipher
   import trivium_pkg::*;
#(
   parameter int unsigned LANES = LANES_DEFAULT,
   parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [8*LANES-1:0]         s_data,
   input  logic                       s_valid,
   output logic                       s_ready,
   output logic [8*LANES-1:0]         m_data,
   output logic                       m_valid,
   input  logic                       m_ready,
   input  logic [8*LANES-1:0]         ks_data,
   input  logic                       ks_valid,
   output logic                       ks_read,
   input  logic                       bypass,
   input  logic                       resync,
   output logic                       resync_req,
   output logic [$clog2(DEPTH+1)-1:0] fifo_level
`ifdef TRIVIUM_STREAM_CNT_EN
   ,
   output logic [BYTE_CNT_W-1:0]      byte_count
`endif
);

   state_e             state_q;
   logic               resync_req_q;
   logic               full, empty, accept, flush;
   logic [8*LANES-1:0] wr_data;

   // full is registered, so s_ready has no path from m_ready.
   assign s_ready    = (state_q == ST_RUN) && !full && (bypass || ks_valid);
   assign accept     = s_valid && s_ready;
   assign ks_read    = accept && !bypass;
   assign wr_data    = bypass ? s_data : (s_data ^ ks_data);
   assign m_valid    = !empty;
   assign flush      = (state_q == ST_FLUSH);
   assign resync_req = resync_req_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_WAIT_HIGH;
         resync_req_q <= 1'b0;
      end else begin
         // Every FLUSH entry is caused by resync, so the pulse tracks it directly.
         resync_req_q <= resync;
         if (resync) begin
            state_q <= ST_FLUSH;
         end else begin
            case (state_q)
               ST_RUN:       state_q <= ST_RUN;
               ST_FLUSH:     state_q <= ST_WAIT_LOW;
               ST_WAIT_LOW:  if (!ks_valid) state_q <= ST_WAIT_HIGH;
               ST_WAIT_HIGH: if (ks_valid)  state_q <= ST_RUN;
               default:      state_q <= ST_WAIT_HIGH;
            endcase
         end
      end
   end

   trivium_sync_fifo #(
      .WIDTH (8*LANES),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (flush),
      .wr_en   (accept),
      .wr_data (wr_data),
      .rd_en   (m_ready),
      .rd_data (m_data),
      .full    (full),
      .empty   (empty),
      .level   (fifo_level)
   );

`ifdef TRIVIUM_STREAM_CNT_EN
   logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;

   always_comb begin
      byte_cnt_d = byte_cnt_q;
      if (flush)       byte_cnt_d = '0;
      else if (accept) byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(LANES);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byte_cnt_q <= '0;
      else        byte_cnt_q <= byte_cnt_d;
   end

   assign byte_count = byte_cnt_q;
`endif

endmodule

// File: tb/tb_trivium_stream_cipher.sv
// tb_trivium_stream_cipher: directed bench with a scoreboard queue for the
// LANES=1/DEPTH=10 instance and direct checks for a LANES=4 instance.
module tb_trivium_stream_cipher;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  s_data, m_data, ks_data;
   logic        s_valid, s_ready, m_valid, m_ready, ks_valid, ks_read;
   logic        bypass, resync, resync_req;
   logic [3:0]  fifo_level;
   logic [31:0] s4_data, m4_data, ks4_data;
   logic        s4_valid, s4_ready, m4_valid, m4_ready, ks4_valid, ks4_read;
   logic        resync_req4;
   logic [2:0]  fifo_level4;
`ifdef TRIVIUM_STREAM_CNT_EN
   logic [31:0] bc1, bc4;
`endif

   int          checks = 0;
   int          errors = 0;
   int          ks_cnt = 0;
   int          rr_cnt = 0;
   logic [7:0]  exp_q[$];

   always #5 clk = ~clk;

   trivium_stream_cipher #(.LANES(1), .DEPTH(10)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .ks_data(ks_data), .ks_valid(ks_valid), .ks_read(ks_read),
      .bypass(bypass), .resync(resync), .resync_req(resync_req),
      .fifo_level(fifo_level)
`ifdef TRIVIUM_STREAM_CNT_EN
      , .byte_count(bc1)
`endif
   );

   trivium_stream_cipher #(.LANES(4), .DEPTH(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n),
      .s_data(s4_data), .s_valid(s4_valid), .s_ready(s4_ready),
      .m_data(m4_data), .m_valid(m4_valid), .m_ready(m4_ready),
      .ks_data(ks4_data), .ks_valid(ks4_valid), .ks_read(ks4_read),
      .bypass(1'b0), .resync(1'b0), .resync_req(resync_req4),
      .fifo_level(fifo_level4)
`ifdef TRIVIUM_STREAM_CNT_EN
      , .byte_count(bc4)
`endif
   );

   // Monitor: pops the scoreboard whenever a beat leaves the FIFO.
   always @(negedge clk) begin
      logic [7:0] e;
      if (rst_n === 1'b1) begin
         if (ks_read)    ks_cnt++;
         if (resync_req) rr_cnt++;
         if (m_valid && m_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_beat: got %02h, expected no beat", m_data);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e) begin
                  errors++;
                  $display("FAIL beat_data: got %02h, expected %02h", m_data, e);
               end
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic send(input logic [7:0] d, input logic [7:0] e);
      int n;
      @(posedge clk); #1;
      s_valid = 1'b1;
      s_data  = d;
      @(negedge clk);
      n = 0;
      while (!s_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!s_ready) begin
         chk("send_timeout_ready", 32'(s_ready), 32'd1);
      end else begin
         @(posedge clk);
         exp_q.push_back(e);
      end
      #1 s_valid = 1'b0;
   endtask

   task automatic wait_level(input string name, input logic [3:0] lvl);
      int n;
      n = 0;
      @(negedge clk);
      while (fifo_level != lvl && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(fifo_level), 32'(lvl));
   endtask

   task automatic wait_ready(input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (!s_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk(name, 32'(s_ready), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      int ks0, rr0, n;
      rst_n = 1'b0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0; ks_data = 8'h5A;
      ks_valid = 1'b0; bypass = 1'b0; resync = 1'b0;
      s4_valid = 1'b0; s4_data = '0; m4_ready = 1'b0; ks4_data = '1; ks4_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_ks_read", 32'(ks_read), 32'd0);
      chk("rst_resync_req", 32'(resync_req), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      ks_valid = 1'b1; ks4_valid = 1'b1;
      @(posedge clk); #1 rst_n = 1'b1;
      wait_ready("run_after_reset");

      // LANES=4 instance: 0x12345678 ^ 0xFFFFFFFF
      @(posedge clk); #1;
      s4_valid = 1'b1; s4_data = 32'h12345678;
      n = 0;
      @(negedge clk);
      while (!s4_ready && n < 20) begin @(negedge clk); n++; end
      chk("lanes4_ready", 32'(s4_ready), 32'd1);
      @(posedge clk); #1 s4_valid = 1'b0;
      @(negedge clk);
      chk("lanes4_valid", 32'(m4_valid), 32'd1);
      chk("lanes4_data", m4_data, 32'hEDCBA987);
`ifdef TRIVIUM_STREAM_CNT_EN
      chk("lanes4_byte_count", bc4, 32'd4);
`endif

      // Basic encrypt: 0x41 ^ 0x5A, FWFT latency, single ks_read
      m_ready = 1'b1;
      ks0 = ks_cnt;
      send(8'h41, 8'h1B);
      @(negedge clk);
      chk("fwft_valid", 32'(m_valid), 32'd1);
      chk("ks_read_pulses", 32'(ks_cnt - ks0), 32'd1);
`ifdef TRIVIUM_STREAM_CNT_EN
      chk("byte_count1", bc1, 32'd1);
`endif

      // Fill to full, check backpressure, drain in order
      @(posedge clk); #1 m_ready = 1'b0;
      for (int i = 0; i < 10; i++) send(8'h10 + 8'(i), (8'h10 + 8'(i)) ^ 8'h5A);
      @(negedge clk);
      chk("full_ready_low", 32'(s_ready), 32'd0);
      chk("full_level", 32'(fifo_level), 32'd10);
      @(posedge clk); #1 s_valid = 1'b1; s_data = 8'hEE;
      repeat (2) @(negedge clk);
      chk("full_hold_level", 32'(fifo_level), 32'd10);
      @(posedge clk); #1 s_valid = 1'b0; m_ready = 1'b1;
      @(negedge clk);
      chk("full_ready_on_pop", 32'(s_ready), 32'd0);
      wait_level("drain_level", 4'd0);
      chk("drain_all_seen", 32'(exp_q.size()), 32'd0);
      send(8'h2A, 8'h2A ^ 8'h5A);
      send(8'h2B, 8'h2B ^ 8'h5A);
      wait_level("wrap_level", 4'd0);
      chk("wrap_all_seen", 32'(exp_q.size()), 32'd0);

      // Simultaneous accept and pop keeps level
      @(posedge clk); #1 m_ready = 1'b0;
      send(8'h01, 8'h01 ^ 8'h5A);
      send(8'h02, 8'h02 ^ 8'h5A);
      @(posedge clk); #1 m_ready = 1'b1; s_valid = 1'b1; s_data = 8'h03;
      @(negedge clk);
      chk("simul_ready", 32'(s_ready), 32'd1);
      @(posedge clk); exp_q.push_back(8'h03 ^ 8'h5A);
      #1 s_valid = 1'b0; m_ready = 1'b0;
      @(negedge clk);
      chk("simul_level", 32'(fifo_level), 32'd2);
      @(posedge clk); #1 m_ready = 1'b1;
      wait_level("simul_drain", 4'd0);

      // Bypass with no keystream; then keystream drop stalls input only
      @(posedge clk); #1 m_ready = 1'b0; bypass = 1'b1; ks_valid = 1'b0;
      ks0 = ks_cnt;
      send(8'h33, 8'h33);
      @(negedge clk);
      chk("bypass_data", 32'(m_data), 32'h33);
      @(posedge clk); #1 bypass = 1'b0;
      @(negedge clk);
      chk("ks_stall_ready", 32'(s_ready), 32'd0);
      @(posedge clk); #1 m_ready = 1'b1;
      wait_level("ks_stall_drain", 4'd0);
      chk("bypass_no_ks_read", 32'(ks_cnt - ks0), 32'd0);
      @(posedge clk); #1 ks_valid = 1'b1;

      // Resync with 4 beats queued
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(8'hA0 + 8'(i), (8'hA0 + 8'(i)) ^ 8'h5A);
      wait_level("resync_pre_level", 4'd4);
      rr0 = rr_cnt;
      @(posedge clk); #1 resync = 1'b1; exp_q.delete();
      @(posedge clk); #1 resync = 1'b0;
      @(negedge clk);
      chk("flush_ready", 32'(s_ready), 32'd0);
      @(negedge clk);
      chk("flush_level", 32'(fifo_level), 32'd0);
      chk("flush_m_valid", 32'(m_valid), 32'd0);
      repeat (2) @(negedge clk);
      chk("wait_low_ready", 32'(s_ready), 32'd0);
      @(posedge clk); #1 ks_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("wait_high_ready", 32'(s_ready), 32'd0);
      @(posedge clk); #1 ks_valid = 1'b1;
      wait_ready("resync_ready_back");
      chk("resync_req_pulses", 32'(rr_cnt - rr0), 32'd1);
      m_ready = 1'b1;
      send(8'h77, 8'h77 ^ 8'h5A);
      wait_level("post_resync_drain", 4'd0);

      // Asynchronous reset with 3 beats queued
      @(posedge clk); #1 m_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(8'hC0 + 8'(i), (8'hC0 + 8'(i)) ^ 8'h5A);
      @(posedge clk); #3 rst_n = 1'b0;
      #1;
      chk("async_rst_m_valid", 32'(m_valid), 32'd0);
      chk("async_rst_level", 32'(fifo_level), 32'd0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1; m_ready = 1'b1;
      repeat (4) @(negedge clk);
      chk("post_reset_empty", 32'(m_valid), 32'd0);
      send(8'h99, 8'h99 ^ 8'h5A);
      wait_level("post_reset_drain", 4'd0);
      chk("final_all_seen", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
